// File: rtl/dmem_arbiter.sv
// Shares one single-ported data memory between the CPU MEM stage (priority) and a DMA port; MEM_LAT-cycle accesses, CPU stalls until done.
// Optional perf counters (stall_cnt_o, conflict_cnt_o) exist only when DMEM_ARB_PERF_EN is defined.
module dmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_LAT   = 1,
  parameter int MAX_GRANT = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_done_o,
  output logic              cpu_stall_o,
  input  logic              dma_req_i,
  input  logic              dma_we_i,
  input  logic [ADDR_W-1:0] dma_addr_i,
  input  logic [DATA_W-1:0] dma_wdata_i,
  output logic [DATA_W-1:0] dma_rdata_o,
  output logic              dma_done_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       conflict_cnt_o
`endif
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int SG_W  = $clog2(MAX_GRANT + 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;
  typedef enum logic {OWN_CPU, OWN_DMA} owner_t;

  state_t            state_q, state_d;
  owner_t            owner_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [SG_W-1:0]   streak_q;
  logic [DATA_W-1:0] cpu_rdata_q, dma_rdata_q;
  logic              grant_cpu, grant_dma;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // DMA wins a tie only once the CPU has used up its streak allowance.
  always_comb begin
    state_d   = state_q;
    grant_cpu = 1'b0;
    grant_dma = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cpu_req_i && dma_req_i) begin
          if (streak_q == SG_W'(MAX_GRANT)) grant_dma = 1'b1;
          else                              grant_cpu = 1'b1;
        end else if (cpu_req_i) begin
          grant_cpu = 1'b1;
        end else if (dma_req_i) begin
          grant_dma = 1'b1;
        end
        if (grant_cpu || grant_dma) state_d = S_BUSY;
      end
      S_BUSY:  if (cnt_q == '0) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      owner_q     <= OWN_CPU;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      streak_q    <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      if (grant_cpu || grant_dma) begin
        owner_q <= grant_dma ? OWN_DMA : OWN_CPU;
        we_q    <= grant_dma ? dma_we_i    : cpu_we_i;
        addr_q  <= grant_dma ? dma_addr_i  : cpu_addr_i;
        wdata_q <= grant_dma ? dma_wdata_i : cpu_wdata_i;
        cnt_q   <= CNT_W'(MEM_LAT - 1);
        if (grant_dma)                          streak_q <= '0;
        else if (streak_q != SG_W'(MAX_GRANT))  streak_q <= streak_q + SG_W'(1);
      end
      if (state_q == S_BUSY) begin
        if (cnt_q != '0) begin
          cnt_q <= cnt_q - CNT_W'(1);
        end else if (!we_q) begin
          if (owner_q == OWN_CPU) cpu_rdata_q <= mem_rdata_i;
          else                    dma_rdata_q <= mem_rdata_i;
        end
      end
    end
  end

  assign mem_read_o  = (state_q == S_BUSY) && !we_q;
  assign mem_write_o = (state_q == S_BUSY) && we_q;
  assign mem_addr_o  = (state_q == S_BUSY) ? addr_q  : '0;
  assign mem_wdata_o = (state_q == S_BUSY) ? wdata_q : '0;
  assign cpu_done_o  = (state_q == S_RESP) && (owner_q == OWN_CPU);
  assign dma_done_o  = (state_q == S_RESP) && (owner_q == OWN_DMA);
  assign cpu_stall_o = cpu_req_i && !cpu_done_o;
  assign cpu_rdata_o = cpu_rdata_q;
  assign dma_rdata_o = dma_rdata_q;

`ifdef DMEM_ARB_PERF_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_o    <= '0;
      conflict_cnt_o <= '0;
    end else begin
      if (cpu_stall_o) stall_cnt_o <= stall_cnt_o + 32'd1;
      if (state_q == S_IDLE && cpu_req_i && dma_req_i) conflict_cnt_o <= conflict_cnt_o + 32'd1;
    end
  end
`endif

endmodule
